// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard controller: the shadow entries that
// hold destination info of in-flight instructions, and the hazard FSM states.
package mips_pkg;

    localparam int SHADOW_AW = 5;
    localparam logic [SHADOW_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [SHADOW_AW-1:0] dst;
        logic                 regwr;
        logic                 memtoreg;
    } shadow_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        RAW_STALL = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Compares the ID-stage source registers against one shadow entry.
// Register $0 and non-writing or invalid entries never produce a match.
module hazard_cmp
    import mips_pkg::*;
(
    input  logic                 sh_valid_i,
    input  logic                 sh_regwr_i,
    input  logic [SHADOW_AW-1:0] sh_dst_i,
    input  logic [SHADOW_AW-1:0] rs_i,
    input  logic [SHADOW_AW-1:0] rt_i,
    input  logic                 use_rs_i,
    input  logic                 use_rt_i,
    output logic                 match_rs_o,
    output logic                 match_rt_o
);

    logic live;

    assign live       = sh_valid_i & sh_regwr_i & (sh_dst_i != REG_ZERO);
    assign match_rs_o = live & use_rs_i & (rs_i == sh_dst_i);
    assign match_rt_o = live & use_rt_i & (rt_i == sh_dst_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, stall/bubble/flush
// and saturating perf counters. Define FORWARDING_EN to enable EX/MEM and MEM/WB forwarding.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_AW = SHADOW_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwr,
    input  logic              id_memtoreg,
    input  logic              id_jump,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              bubble,
    output logic              flush_ifid,
    output logic              ex_forward_a,
    output logic              ex_forward_b,
    output logic              mem_forward_a,
    output logic              mem_forward_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        dbg_state_o
);

    shadow_t    ex_q, ex_d, mem_q;
    hz_state_e  state_q, state_d;
    logic       use_rs, use_rt;
    logic       match_rs_ex, match_rt_ex, match_rs_mem, match_rt_mem;
    logic       need_stall;
    logic       ex_fwd_a_q, ex_fwd_b_q, mem_fwd_a_q, mem_fwd_b_q;
    logic       ex_fwd_a_d, ex_fwd_b_d, mem_fwd_a_d, mem_fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [1:0] shadow_unused;

    // An empty ID slot must never look like a consumer.
    assign use_rs = id_valid & id_use_rs;
    assign use_rt = id_valid & id_use_rt;

    hazard_cmp u_cmp_ex (
        .sh_valid_i (ex_q.valid),
        .sh_regwr_i (ex_q.regwr),
        .sh_dst_i   (ex_q.dst),
        .rs_i       (id_rs),
        .rt_i       (id_rt),
        .use_rs_i   (use_rs),
        .use_rt_i   (use_rt),
        .match_rs_o (match_rs_ex),
        .match_rt_o (match_rt_ex)
    );

    hazard_cmp u_cmp_mem (
        .sh_valid_i (mem_q.valid),
        .sh_regwr_i (mem_q.regwr),
        .sh_dst_i   (mem_q.dst),
        .rs_i       (id_rs),
        .rt_i       (id_rt),
        .use_rs_i   (use_rs),
        .use_rt_i   (use_rt),
        .match_rs_o (match_rs_mem),
        .match_rt_o (match_rt_mem)
    );

`ifdef FORWARDING_EN
    localparam hz_state_e STALL_STATE = LU_STALL;

    // Only a load sitting in EX cannot be forwarded in time.
    assign need_stall    = (match_rs_ex | match_rt_ex) & ex_q.memtoreg;
    assign ex_fwd_a_d    = match_rs_ex & ~bubble;
    assign ex_fwd_b_d    = match_rt_ex & ~bubble;
    assign mem_fwd_a_d   = match_rs_mem & ~match_rs_ex & ~bubble;
    assign mem_fwd_b_d   = match_rt_mem & ~match_rt_ex & ~bubble;
    assign shadow_unused = {1'b0, mem_q.memtoreg};
`else
    localparam hz_state_e STALL_STATE = RAW_STALL;

    // Without forwarding every in-flight producer blocks the consumer.
    assign need_stall    = match_rs_ex | match_rt_ex | match_rs_mem | match_rt_mem;
    assign ex_fwd_a_d    = 1'b0;
    assign ex_fwd_b_d    = 1'b0;
    assign mem_fwd_a_d   = 1'b0;
    assign mem_fwd_b_d   = 1'b0;
    assign shadow_unused = {ex_q.memtoreg, mem_q.memtoreg};
`endif

    // Taken branch outranks stalls; a jump squashes its slot only when ID advances.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        bubble     = 1'b0;
        flush_ifid = 1'b0;
        if (rst) begin
            if (ex_branch_taken) begin
                bubble     = 1'b1;
                flush_ifid = 1'b1;
                state_d    = RUN;
            end else begin
                case (state_q)
                    LU_STALL: state_d = RUN;
                    RUN, RAW_STALL: begin
                        if (need_stall) begin
                            stall   = 1'b1;
                            bubble  = 1'b1;
                            state_d = STALL_STATE;
                        end else begin
                            state_d = RUN;
                        end
                    end
                    default: state_d = RUN;
                endcase
                flush_ifid = id_valid & id_jump & ~stall;
            end
        end
    end

    always_comb begin
        ex_d.valid    = id_valid & ~bubble;
        ex_d.dst      = id_dst;
        ex_d.regwr    = id_regwr;
        ex_d.memtoreg = id_memtoreg;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_ifid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            ex_fwd_a_q  <= 1'b0;
            ex_fwd_b_q  <= 1'b0;
            mem_fwd_a_q <= 1'b0;
            mem_fwd_b_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            ex_fwd_a_q  <= ex_fwd_a_d;
            ex_fwd_b_q  <= ex_fwd_b_d;
            mem_fwd_a_q <= mem_fwd_a_d;
            mem_fwd_b_q <= mem_fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_forward_a  = ex_fwd_a_q;
    assign ex_forward_b  = ex_fwd_b_q;
    assign mem_forward_a = mem_fwd_a_q;
    assign mem_forward_b = mem_fwd_b_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed MIPS sequences plus randomized traffic, all checked
// against an instruction-level pipeline model. Follows the FORWARDING_EN build of the DUT.
module tb_hazard_ctrl;
    import mips_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FORWARDING_EN
    localparam int MAX_RUN = 1;
    localparam hz_state_e STALLED = LU_STALL;
`else
    localparam int MAX_RUN = 2;
    localparam hz_state_e STALLED = RAW_STALL;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic id_regwr = 1'b0, id_memtoreg = 1'b0, id_jump = 1'b0, ex_branch_taken = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
    logic stall, bubble, flush_ifid;
    logic ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regwr(id_regwr),
        .id_memtoreg(id_memtoreg), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
        .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid),
        .ex_forward_a(ex_forward_a), .ex_forward_b(ex_forward_b),
        .mem_forward_a(mem_forward_a), .mem_forward_b(mem_forward_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state_o(dbg_state)
    );

    // Model: the instructions currently in EX (pipe[0]) and MEM (pipe[1]).
    typedef struct { bit valid; int dst; bit regwr; bit load; } instr_t;
    instr_t pipe[2];
    int  checks = 0, failures = 0;
    bit  m_stall = 0, m_bubble = 0, m_flush = 0;
    bit  e_exa = 0, e_exb = 0, e_mema = 0, e_memb = 0;
    int  m_scnt = 0, m_fcnt = 0, run_len = 0;
    hz_state_e m_state = RUN;
    bit  prev_stall = 0, prev_flush = 0;
    logic s_stall, s_bubble, s_flush, s_exa, s_exb, s_mema, s_memb;
    logic [CNT_W-1:0] s_scnt, s_fcnt;
    logic [1:0] s_state;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 1 = newest writer of r is in EX, 2 = in MEM, 0 = none in flight.
    function automatic int producer(input int r);
        for (int s = 0; s < 2; s++)
            if (pipe[s].valid && pipe[s].regwr && pipe[s].dst != 0 && pipe[s].dst == r)
                return s + 1;
        return 0;
    endfunction

    task automatic run_cycle();
        int pa, pb;
        bit need;
        @(negedge clk);
        s_stall = stall; s_bubble = bubble; s_flush = flush_ifid;
        s_exa = ex_forward_a; s_exb = ex_forward_b; s_mema = mem_forward_a; s_memb = mem_forward_b;
        s_scnt = stall_cnt; s_fcnt = flush_cnt; s_state = dbg_state;
        pa = (id_valid && id_use_rs) ? producer(int'(id_rs)) : 0;
        pb = (id_valid && id_use_rt) ? producer(int'(id_rt)) : 0;
`ifdef FORWARDING_EN
        need = (pa == 1 || pb == 1) && pipe[0].load;
`else
        need = (pa != 0) || (pb != 0);
`endif
        if (!rst) begin
            m_stall = 0; m_bubble = 0; m_flush = 0;
        end else begin
            m_stall  = need && !ex_branch_taken;
            m_bubble = m_stall || ex_branch_taken;
            m_flush  = ex_branch_taken || (id_valid && id_jump && !m_stall);
        end
        chk("stall", s_stall, m_stall);
        chk("bubble", s_bubble, m_bubble);
        chk("flush_ifid", s_flush, m_flush);
        chk("ex_forward_a", s_exa, e_exa);
        chk("ex_forward_b", s_exb, e_exb);
        chk("mem_forward_a", s_mema, e_mema);
        chk("mem_forward_b", s_memb, e_memb);
        chk("stall_cnt", s_scnt, m_scnt);
        chk("flush_cnt", s_fcnt, m_fcnt);
        chk("state", s_state, m_state);
        run_len = s_stall ? run_len + 1 : 0;
        if (s_stall) chk("stall_run_bound", (run_len <= MAX_RUN), 1);
        if (!rst) begin
            pipe[0] = '{0, 0, 0, 0};
            pipe[1] = '{0, 0, 0, 0};
            e_exa = 0; e_exb = 0; e_mema = 0; e_memb = 0;
            m_scnt = 0; m_fcnt = 0; m_state = RUN;
        end else begin
`ifdef FORWARDING_EN
            e_exa  = (pa == 1) && !m_bubble;
            e_exb  = (pb == 1) && !m_bubble;
            e_mema = (pa == 2) && !m_bubble;
            e_memb = (pb == 2) && !m_bubble;
`endif
            pipe[1] = pipe[0];
            pipe[0] = '{id_valid && !m_bubble, int'(id_dst), id_regwr, id_memtoreg};
            if (m_stall && m_scnt < CNT_MAX) m_scnt++;
            if (m_flush && m_fcnt < CNT_MAX) m_fcnt++;
            m_state = m_stall ? STALLED : RUN;
        end
        prev_stall = m_stall;
        prev_flush = m_flush;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input int dst, input bit wr, input bit ld);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
        id_dst = 5'(dst); id_regwr = wr; id_memtoreg = ld; id_jump = 0; ex_branch_taken = 0;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 0;
        nop();
        run_cycle();
        rst = 1;
    endtask

    task automatic drive_random();
        rst = ($urandom_range(0, 79) != 0);
        if (!prev_stall) begin
            id_valid    = prev_flush ? 1'b0 : ($urandom_range(0, 3) != 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom_range(0, 1));
            id_use_rt   = 1'($urandom_range(0, 1));
            id_dst      = 5'($urandom_range(0, 3));
            id_regwr    = 1'($urandom_range(0, 1));
            id_memtoreg = id_regwr && ($urandom_range(0, 2) == 0);
            id_jump     = ($urandom_range(0, 9) == 0);
        end
        ex_branch_taken = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        pipe[0] = '{0, 0, 0, 0};
        pipe[1] = '{0, 0, 0, 0};
        nop();
        run_cycle();
        chk("reset_stall", s_stall, 0);
        chk("reset_stall_cnt", s_scnt, 0);
        chk("reset_state", s_state, RUN);
        rst = 1;

        // addi $1,$0,2015 ; add $1,$1,$2
        do_reset();
        set_id(1, 0, 0, 1, 0, 1, 1, 0); run_cycle();
        set_id(1, 1, 2, 1, 1, 1, 1, 0); run_cycle();
`ifdef FORWARDING_EN
        chk("t1_stall", s_stall, 0);
        nop(); run_cycle();
        chk("t1_ex_fwd_a", s_exa, 1);
        chk("t1_mem_fwd_a", s_mema, 0);
`else
        chk("t1_stall_c0", s_stall, 1);
        run_cycle();
        chk("t1_stall_c1", s_stall, 1);
        run_cycle();
        chk("t1_stall_c2", s_stall, 0);
`endif

        // addi $2,$0,404 ; nop ; add $3,$1,$2
        do_reset();
        set_id(1, 0, 0, 1, 0, 2, 1, 0); run_cycle();
        nop(); run_cycle();
        set_id(1, 1, 2, 1, 1, 3, 1, 0); run_cycle();
`ifdef FORWARDING_EN
        chk("t2_stall", s_stall, 0);
        nop(); run_cycle();
        chk("t2_mem_fwd_b", s_memb, 1);
        chk("t2_ex_fwd_b", s_exb, 0);
`else
        chk("t2_stall_c0", s_stall, 1);
        run_cycle();
        chk("t2_stall_c1", s_stall, 0);
`endif

        // lw $3,0($0) ; add $4,$3,$1
        do_reset();
        set_id(1, 0, 0, 1, 0, 3, 1, 1); run_cycle();
        set_id(1, 3, 1, 1, 1, 4, 1, 0); run_cycle();
        chk("t3_stall", s_stall, 1);
        chk("t3_bubble", s_bubble, 1);
        run_cycle();
`ifdef FORWARDING_EN
        chk("t3_stall_after", s_stall, 0);
        nop(); run_cycle();
        chk("t3_mem_fwd_a", s_mema, 1);
        chk("t3_stall_cnt", s_scnt, 1);
`else
        chk("t3_stall_c1", s_stall, 1);
        run_cycle();
        chk("t3_stall_c2", s_stall, 0);
        chk("t3_stall_cnt", s_scnt, 2);
`endif

        // addi $0,$0,5 ; add $5,$0,$0
        do_reset();
        set_id(1, 0, 0, 1, 0, 0, 1, 0); run_cycle();
        set_id(1, 0, 0, 1, 1, 5, 1, 0); run_cycle();
        chk("t4_stall", s_stall, 0);
        nop(); run_cycle();
        chk("t4_fwd_any", {s_exa, s_exb, s_mema, s_memb}, 0);

        // load-use stall cycle coinciding with a taken branch
        do_reset();
        set_id(1, 0, 0, 1, 0, 3, 1, 1); run_cycle();
        set_id(1, 3, 1, 1, 1, 4, 1, 0); ex_branch_taken = 1; run_cycle();
        chk("t5_flush", s_flush, 1);
        chk("t5_bubble", s_bubble, 1);
        chk("t5_stall", s_stall, 0);
        nop(); run_cycle();
        chk("t5_state", s_state, RUN);
        chk("t5_flush_cnt", s_fcnt, 1);

        // reset while the load-use stall is being served
        do_reset();
        set_id(1, 0, 0, 1, 0, 3, 1, 1); run_cycle();
        set_id(1, 3, 1, 1, 1, 4, 1, 0); run_cycle();
        chk("t6_stall", s_stall, 1);
        rst = 0; run_cycle();
        chk("t6_state_in_stall", s_state, STALLED);
        chk("t6_reset_gates_stall", s_stall, 0);
        rst = 1; set_id(1, 3, 1, 1, 1, 4, 1, 0); run_cycle();
        chk("t6_post_stall", s_stall, 0);
        chk("t6_post_stall_cnt", s_scnt, 0);
        chk("t6_post_flush_cnt", s_fcnt, 0);
        chk("t6_post_state", s_state, RUN);
        nop(); run_cycle();
        chk("t6_no_stale_fwd", {s_exa, s_exb, s_mema, s_memb}, 0);

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
